// File: rtl/ovi_pkg.sv
// Shared OVI definitions used by the core-side issue transmitter and the
// VPU-side issue queue.
//   OVI_SBID_W  : width of the scoreboard ID carried on issue/dispatch
//   ovi_issue_t : packed issue payload (instruction, scalar operand, vCSR)
package ovi_pkg;

  localparam int OVI_SBID_W = 5;

  typedef struct packed {
    logic [31:0] inst;
    logic [63:0] scalar_opnd;
    logic [39:0] vcsr;
    logic        vcsr_lmulb2;
  } ovi_issue_t;

endpackage

// File: rtl/ovi_sbid_fifo.sv
// Pending-list FIFO of speculative sb_ids for ovi_issue_tx.
// Ports:
//   clk, reset_n   : clock, synchronous active-low reset
//   push, push_id  : append an sb_id at the tail
//   pop            : drop the head entry
//   clear          : empty the list in one cycle (has priority over push/pop)
//   head           : oldest sb_id (valid while count != 0)
//   count          : number of entries held
module ovi_sbid_fifo
  import ovi_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic                          push,
  input  logic [OVI_SBID_W-1:0]         push_id,
  input  logic                          pop,
  input  logic                          clear,
  output logic [OVI_SBID_W-1:0]         head,
  output logic [$clog2(DEPTH+1)-1:0]    count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  logic [OVI_SBID_W-1:0] mem [DEPTH];
  logic [PW-1:0]         wr_ptr;
  logic [PW-1:0]         rd_ptr;
  logic [CW-1:0]         cnt;

  // DEPTH is a power of two, so the pointers wrap naturally.
  always_ff @(posedge clk) begin
    if (!reset_n || clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      cnt <= cnt + CW'(push) - CW'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (push && !clear) mem[wr_ptr] <= push_id;
  end

  assign head  = mem[rd_ptr];
  assign count = cnt;

endmodule

// File: rtl/ovi_issue_tx.sv
// Core-side OVI issue/dispatch transmitter.
// Accepts vector instructions, tags them with a wrapping 5-bit sb_id, issues
// them under a credit scheme matched to the VPU issue queue, and turns core
// commit/flush events into dispatch_next_senior / dispatch_kill commands.
// Ports:
//   in_*            : instruction handshake and payload from the scalar core
//   commit_valid    : oldest speculative issued instruction becomes senior
//   flush_valid     : all speculative issued instructions are killed
//   issue_credit    : VPU freed one queue entry
//   issue_*         : registered issue beat
//   dispatch_*      : registered dispatch command (next_senior or kill)
//   credits         : credits currently available
//   protocol_err    : sticky protocol error flag
// Build option: define OVI_ISSUE_TX_PROTO_CHECK_EN to enable protocol_err and
// simulation assertions; otherwise protocol_err is tied low.
module ovi_issue_tx
  import ovi_pkg::*;
#(
  parameter int CREDITS = 4
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [31:0]                   in_inst,
  input  logic [63:0]                   in_scalar_opnd,
  input  logic [39:0]                   in_vcsr,
  input  logic                          in_vcsr_lmulb2,
  input  logic                          in_senior,
  input  logic                          commit_valid,
  input  logic                          flush_valid,
  input  logic                          issue_credit,
  output logic                          issue_valid,
  output logic [31:0]                   issue_inst,
  output logic [OVI_SBID_W-1:0]         issue_sb_id,
  output logic [63:0]                   issue_scalar_opnd,
  output logic [39:0]                   issue_vcsr,
  output logic                          issue_vcsr_lmulb2,
  output logic [OVI_SBID_W-1:0]         dispatch_sb_id,
  output logic                          dispatch_next_senior,
  output logic                          dispatch_kill,
  output logic [$clog2(CREDITS+1)-1:0]  credits,
  output logic                          protocol_err
);

  localparam int CW = $clog2(CREDITS + 1);
  localparam int SW = CW + 1;

  logic [CW-1:0]         cred_q;
  logic [OVI_SBID_W-1:0] sb_ctr;
  logic                  kill_block;
  ovi_issue_t            in_payload;
  ovi_issue_t            issue_p1;

  logic [OVI_SBID_W-1:0] pend_head;
  logic [CW-1:0]         pend_cnt;
  logic                  has_pend;
  logic                  accept;
  logic                  commit_hit;
  logic                  flush_hit;
  logic [CW-1:0]         killed;
  logic [SW-1:0]         cred_sum;
  logic                  cred_ovf;
  logic [CW-1:0]         cred_next;

  assign has_pend = (pend_cnt != '0);

  // Senior instructions wait for an empty pending list so their
  // next_senior cannot overtake an older speculative entry; kill_block
  // forces a next_senior between two kills, which the VPU needs.
  assign in_ready = reset_n && (cred_q != '0) && !flush_valid &&
                    !(commit_valid && has_pend) && !(in_senior && has_pend) &&
                    (in_senior || !kill_block);

  assign accept     = in_valid && in_ready;
  assign flush_hit  = flush_valid && has_pend;
  assign commit_hit = commit_valid && has_pend && !flush_valid;
  // The VPU rewinds its write pointer over killed entries, returning them.
  assign killed     = flush_hit ? pend_cnt : '0;

  assign cred_sum  = {1'b0, cred_q} + SW'(issue_credit) + {1'b0, killed} - SW'(accept);
  assign cred_ovf  = (cred_sum > SW'(CREDITS));
  assign cred_next = cred_ovf ? CW'(CREDITS) : cred_sum[CW-1:0];

  assign in_payload.inst        = in_inst;
  assign in_payload.scalar_opnd = in_scalar_opnd;
  assign in_payload.vcsr        = in_vcsr;
  assign in_payload.vcsr_lmulb2 = in_vcsr_lmulb2;

  ovi_sbid_fifo #(
    .DEPTH (CREDITS)
  ) u_pend (
    .clk     (clk),
    .reset_n (reset_n),
    .push    (accept && !in_senior),
    .push_id (sb_ctr),
    .pop     (commit_hit),
    .clear   (flush_hit),
    .head    (pend_head),
    .count   (pend_cnt)
  );

  // Stage p0 -> p1: register issue beat and dispatch command.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      issue_valid          <= 1'b0;
      issue_p1             <= '0;
      issue_sb_id          <= '0;
      dispatch_next_senior <= 1'b0;
      dispatch_kill        <= 1'b0;
      dispatch_sb_id       <= '0;
      cred_q               <= CW'(CREDITS);
      sb_ctr               <= '0;
      kill_block           <= 1'b0;
    end else begin
      issue_valid          <= accept;
      dispatch_next_senior <= 1'b0;
      dispatch_kill        <= 1'b0;
      if (accept) begin
        issue_p1    <= in_payload;
        issue_sb_id <= sb_ctr;
        sb_ctr      <= sb_ctr + OVI_SBID_W'(1);
      end
      // Flush, commit and senior accept are mutually exclusive by in_ready.
      if (flush_hit) begin
        dispatch_kill  <= 1'b1;
        dispatch_sb_id <= pend_head;
        kill_block     <= 1'b1;
      end else if (commit_hit) begin
        dispatch_next_senior <= 1'b1;
        dispatch_sb_id       <= pend_head;
        kill_block           <= 1'b0;
      end else if (accept && in_senior) begin
        dispatch_next_senior <= 1'b1;
        dispatch_sb_id       <= sb_ctr;
        kill_block           <= 1'b0;
      end
      cred_q <= cred_next;
    end
  end

  assign issue_inst        = issue_p1.inst;
  assign issue_scalar_opnd = issue_p1.scalar_opnd;
  assign issue_vcsr        = issue_p1.vcsr;
  assign issue_vcsr_lmulb2 = issue_p1.vcsr_lmulb2;
  assign credits           = cred_q;

`ifdef OVI_ISSUE_TX_PROTO_CHECK_EN
  logic perr_q;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      perr_q <= 1'b0;
    end else if (cred_ovf || (commit_valid && flush_valid) ||
                 (commit_valid && !has_pend)) begin
      perr_q <= 1'b1;
    end
  end

  assign protocol_err = perr_q;

  always_ff @(posedge clk) begin
    if (reset_n) begin
      assert (!(dispatch_kill && dispatch_next_senior));
      assert (!(dispatch_kill && issue_valid));
      assert (pend_cnt <= CW'(CREDITS));
    end
  end
`else
  assign protocol_err = 1'b0;
`endif

endmodule
